// File: rtl/hamm_pkg.sv
// Shared constants and types for the Hamming(7,4) port merger.
// Codeword bit k holds Hamming position k+1.
package hamm_pkg;

  localparam int NPORTS = 4;
  localparam int CW_W   = 7;
  localparam int DATA_W = 4;
  localparam int PORT_W = 2;
  localparam int OUT_W  = PORT_W + DATA_W;
  localparam int CNT_W  = 8;

  // Hamming positions (1-based) of parity and data bits
  localparam int POS_P1 = 1;
  localparam int POS_P2 = 2;
  localparam int POS_D0 = 3;
  localparam int POS_P4 = 4;
  localparam int POS_D1 = 5;
  localparam int POS_D2 = 6;
  localparam int POS_D3 = 7;

  typedef logic [CW_W-1:0] cw_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
    logic [2:0]        err_pos;
  } dec_res_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/hamm_syndrome_decode.sv
// Combinational Hamming(7,4) single-error corrector: codeword in,
// corrected nibble plus error flag and corrected position out.
module hamm_syndrome_decode
  import hamm_pkg::*;
(
  input  cw_t      cw,
  output dec_res_t res
);

  logic [2:0] syn;

  always_comb begin
    syn[0] = cw[POS_P1-1] ^ cw[POS_D0-1] ^ cw[POS_D1-1] ^ cw[POS_D3-1];
    syn[1] = cw[POS_P2-1] ^ cw[POS_D0-1] ^ cw[POS_D2-1] ^ cw[POS_D3-1];
    syn[2] = cw[POS_P4-1] ^ cw[POS_D1-1] ^ cw[POS_D2-1] ^ cw[POS_D3-1];
  end

  // A data bit flips only when the syndrome points at its own position;
  // parity-bit errors leave the nibble untouched.
  always_comb begin
    res.data[0] = cw[POS_D0-1] ^ (syn == 3'(POS_D0));
    res.data[1] = cw[POS_D1-1] ^ (syn == 3'(POS_D1));
    res.data[2] = cw[POS_D2-1] ^ (syn == 3'(POS_D2));
    res.data[3] = cw[POS_D3-1] ^ (syn == 3'(POS_D3));
    res.err     = |syn;
    res.err_pos = syn;
  end

endmodule

// File: rtl/hamming_port_merger.sv
// Four single-word port buffers, round-robin arbiter, Hamming correction on
// the granted word, and a registered one-word output stage.
module hamming_port_merger
  import hamm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NPORTS-1:0]    in_valid,
  input  logic [CW_W-1:0]      in_data0,
  input  logic [CW_W-1:0]      in_data1,
  input  logic [CW_W-1:0]      in_data2,
  input  logic [CW_W-1:0]      in_data3,
  output logic [NPORTS-1:0]    in_ready,
  output logic                 out_valid,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_err,
  output logic [2:0]           out_err_pos,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     corr_cnt
);

  cw_t               cw_in    [NPORTS];
  cw_t               buf_data [NPORTS];
  logic [NPORTS-1:0] buf_full;
  logic [PORT_W-1:0] rr_ptr;
  logic [PORT_W-1:0] grant;
  logic              grant_vld;
  logic              load;
  dec_res_t          dec;
  out_state_t        state, state_nxt;

  assign cw_in[0] = in_data0;
  assign cw_in[1] = in_data1;
  assign cw_in[2] = in_data2;
  assign cw_in[3] = in_data3;

  // in_ready is a register in disguise: it is just the inverted full flags.
  assign in_ready = ~buf_full;

  // Arbiter: walk downward so the lowest offset from rr_ptr wins.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      if (buf_full[rr_ptr + PORT_W'(k)]) begin
        grant     = rr_ptr + PORT_W'(k);
        grant_vld = 1'b1;
      end
    end
  end

  assign load = grant_vld && ((state == ST_EMPTY) || out_ready);

  hamm_syndrome_decode u_dec (
    .cw  (buf_data[grant]),
    .res (dec)
  );

  // A granted buffer is always full, so it never accepts in its grant cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full <= '0;
      // NOTE: buffer contents are reset too so a mid-run reset leaves no stale words visible.
      for (int i = 0; i < NPORTS; i++) buf_data[i] <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (load && grant == PORT_W'(i)) begin
          buf_full[i] <= 1'b0;
        end else if (in_valid[i] && !buf_full[i]) begin
          buf_full[i] <= 1'b1;
          buf_data[i] <= cw_in[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
      rr_ptr      <= '0;
      out_data    <= '0;
      out_err     <= 1'b0;
      out_err_pos <= '0;
      corr_cnt    <= '0;
    end else if (load) begin
      rr_ptr      <= grant + PORT_W'(1);
      out_data    <= {grant, dec.data};
      out_err     <= dec.err;
      out_err_pos <= dec.err_pos;
      if (dec.err && corr_cnt != '1) corr_cnt <= corr_cnt + CNT_W'(1);
    end
  end

  // Output-stage FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // Output-stage FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (grant_vld) state_nxt = ST_FULL;
      ST_FULL:  if (out_ready && !grant_vld) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // Output-stage FSM: outputs
  always_comb begin
    out_valid = (state == ST_FULL);
  end

endmodule

// File: tb/tb_hamming_port_merger.sv
// Directed bench for hamming_port_merger: vector table of single words plus
// round-robin, backpressure, saturation and async-reset sequences.
module tb_hamming_port_merger;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [6:0] in_data [4];
  logic [3:0] in_ready;
  logic       out_valid;
  logic [5:0] out_data;
  logic       out_err;
  logic [2:0] out_err_pos;
  logic       out_ready;
  logic [7:0] corr_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  hamming_port_merger dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data0    (in_data[0]),
    .in_data1    (in_data[1]),
    .in_data2    (in_data[2]),
    .in_data3    (in_data[3]),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_err     (out_err),
    .out_err_pos (out_err_pos),
    .out_ready   (out_ready),
    .corr_cnt    (corr_cnt)
  );

  typedef struct {
    logic [1:0] port;
    logic [6:0] cw;
    logic [5:0] exp_out;
    logic       exp_err;
    logic [2:0] exp_pos;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  function automatic logic [6:0] flip(input logic [6:0] cw, input int pos);
    logic [6:0] r;
    r = cw;
    if (pos != 0) r[pos-1] = ~r[pos-1];
    return r;
  endfunction

  task automatic do_reset();
    in_valid  = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    exp_cnt   = 0;
    @(negedge clk);
  endtask

  // Word accepted at the next edge; returns one edge later, after the load.
  task automatic send_one(input logic [1:0] p, input logic [6:0] cw);
    @(negedge clk);
    in_data[p]  = cw;
    in_valid[p] = 1'b1;
    @(negedge clk);
    in_valid    = '0;
    @(negedge clk);
  endtask

  task automatic check_word(input string name, input logic [5:0] exp_out,
                            input logic exp_err, input logic [2:0] exp_pos);
    check({name, ".valid"}, out_valid, 1'b1);
    check({name, ".data"},  out_data,  exp_out);
    check({name, ".err"},   out_err,   exp_err);
    check({name, ".pos"},   out_err_pos, exp_pos);
    check({name, ".cnt"},   corr_cnt,  exp_cnt);
  endtask

  // Loads all ports in mask with enc(nib[i]) in one cycle; returns at the
  // negedge right after the accepting edge.
  task automatic burst(input logic [3:0] mask, input logic [3:0] nib [4]);
    @(negedge clk);
    for (int i = 0; i < 4; i++) in_data[i] = enc(nib[i]);
    in_valid = mask;
    @(negedge clk);
    in_valid = '0;
  endtask

  initial begin
    logic [3:0] nibs [4];
    int         order [4];
    int         n_loads;
    logic [5:0] held;

    nibs = '{4'h3, 4'h5, 4'hA, 4'hC};

    vecs[0] = '{2'd1, 7'b1010101, 6'b01_1011, 1'b0, 3'd0};
    vecs[1] = '{2'd2, 7'b1010001, 6'b10_1011, 1'b1, 3'd3};
    vecs[2] = '{2'd3, 7'b0111111, 6'b11_1111, 1'b1, 3'd7};
    vecs[3] = '{2'd0, 7'b0000110, 6'b00_0001, 1'b1, 3'd1};
    vecs[4] = '{2'd0, 7'b0000000, 6'b00_0000, 1'b0, 3'd0};

    for (int i = 0; i < 4; i++) in_data[i] = '0;
    do_reset();

    check("reset.in_ready",  in_ready,    4'b1111);
    check("reset.out_valid", out_valid,   1'b0);
    check("reset.out_data",  out_data,    6'd0);
    check("reset.out_err",   out_err,     1'b0);
    check("reset.pos",       out_err_pos, 3'd0);
    check("reset.corr_cnt",  corr_cnt,    8'd0);

    // Hand-computed vector table
    for (int v = 0; v < 5; v++) begin
      send_one(vecs[v].port, vecs[v].cw);
      if (vecs[v].exp_err) exp_cnt++;
      check_word($sformatf("vec%0d", v), vecs[v].exp_out, vecs[v].exp_err, vecs[v].exp_pos);
    end

    // Every nibble with every single-bit error position (0 = clean)
    for (int nib = 0; nib < 16; nib++) begin
      for (int pos = 0; pos < 8; pos++) begin
        logic [1:0] p;
        p = 2'((nib + pos) % 4);
        send_one(p, flip(enc(4'(nib)), pos));
        if (pos != 0) exp_cnt++;
        check_word($sformatf("sweep_n%0d_p%0d", nib, pos), {p, 4'(nib)}, pos != 0, 3'(pos));
      end
    end
    @(negedge clk);
    check("sweep.drained", out_valid, 1'b0);

    // Round-robin from rr_ptr=0
    do_reset();
    burst(4'b1111, nibs);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_word($sformatf("rr0_%0d", k), {2'(k), nibs[k]}, 1'b0, 3'd0);
    end
    @(negedge clk);
    check("rr0.empty", out_valid, 1'b0);

    // Round-robin from rr_ptr=2 (a grant on port 1 moves the pointer there)
    send_one(2'd1, enc(4'h9));
    check_word("rr2.pre", {2'd1, 4'h9}, 1'b0, 3'd0);
    burst(4'b1111, nibs);
    order = '{2, 3, 0, 1};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_word($sformatf("rr2_%0d", k), {2'(order[k]), nibs[order[k]]}, 1'b0, 3'd0);
    end

    // Backpressure: hold out_ready low for 5 cycles
    do_reset();
    out_ready = 1'b0;
    burst(4'b1111, nibs);
    check("bp.all_full", in_ready, 4'b0000);
    @(negedge clk);
    check_word("bp.first", {2'd0, nibs[0]}, 1'b0, 3'd0);
    held = out_data;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp.hold%0d.data", c), out_data, held);
      check($sformatf("bp.hold%0d.valid", c), out_valid, 1'b1);
      check($sformatf("bp.hold%0d.ready", c), in_ready, 4'b0001);
    end
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check_word($sformatf("bp.rel%0d", k), {2'(k), nibs[k]}, 1'b0, 3'd0);
    end
    @(negedge clk);
    check("bp.no_dup", out_valid, 1'b0);
    check("bp.ready_back", in_ready, 4'b1111);

    // Counter saturation: continuous corrupted words on all ports
    do_reset();
    for (int i = 0; i < 4; i++) in_data[i] = flip(enc(4'h6), 5);
    in_valid = 4'b1111;
    n_loads  = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (out_valid && out_err) n_loads++;
      if (n_loads == 100 && c < 400) begin
        check("sat.mid", corr_cnt, 8'd100);
        n_loads++;
        n_loads--;
      end
    end
    in_valid = '0;
    check("sat.enough_words", n_loads >= 300, 1'b1);
    check("sat.cnt", corr_cnt, 8'd255);

    // Async reset between edges in the middle of a burst
    burst(4'b1111, nibs);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset.out_valid", out_valid, 1'b0);
    check("areset.in_ready",  in_ready,  4'b1111);
    check("areset.corr_cnt",  corr_cnt,  8'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 0;
    burst(4'b1001, nibs);
    @(negedge clk);
    check_word("areset.first", {2'd0, nibs[0]}, 1'b0, 3'd0);
    @(negedge clk);
    check_word("areset.second", {2'd3, nibs[3]}, 1'b0, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_port_merger.md
# hamming_port_merger

Receive side of the 4-port Hamming router. Accepts Hamming(7,4) codewords from four independent output ports over valid/ready handshakes. Buffers one word per port, corrects single-bit errors, and merges the four streams round-robin into one registered 6-bit stream {src_port[1:0], data[3:0]}. This is the inverse of the router's address/encode step, and sits between the four (possibly corrupted) port links and the consumer.

## Interface
- No parameters. Port count is fixed at 4 and the code is fixed at Hamming(7,4); both are constants in the shared package.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  4  per-port word valid; bit i belongs to port i.
- in_data0..in_data3  input  7 each  codeword; bit k holds Hamming position k+1.
- in_ready  output  4  per-port ready; registered, equal to ~buf_full[i].
- out_valid  output  1  merged word valid.
- out_data  output  6  {src_port[1:0], corrected data[3:0]}.
- out_err  output  1  1 = a single-bit error was corrected in this word.
- out_err_pos  output  3  corrected Hamming position (1..7); 0 when out_err=0.
- out_ready  input  1  consumer ready.
- corr_cnt  output  8  saturating count of corrected words.

## Operation
- **Code layout.** Positions: 1=p1, 2=p2, 3=d0, 4=p4, 5=d1, 6=d2, 7=d3.
  - p1 = d0^d1^d3, p2 = d0^d2^d3, p4 = d1^d2^d3.
  - Syndrome s = {s4,s2,s1}: s1 = ^pos{1,3,5,7}, s2 = ^pos{2,3,6,7}, s4 = ^pos{4,5,6,7}.
  - s≠0: flip position s, out_err=1, out_err_pos=s. s=0: pass the word unchanged.
  - Double errors are not detected; they are miscorrected by design.
- **Input buffers.** One 7-bit register plus a full flag per port.
  - A word is accepted when in_valid[i] & in_ready[i]; the buffer sets full at that edge.
  - A full buffer clears at the edge it is granted.
- **Output stage FSM.**
  - States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - The stage can load when state is EMPTY, or when FULL & out_ready (drain-and-refill in the same cycle).
  - Load happens if any buffer is full. Otherwise: FULL & out_ready goes to EMPTY; EMPTY stays EMPTY.
  - FULL & !out_ready holds out_data, out_err and out_err_pos stable.
- **Arbiter.**
  - Grant goes to the first full buffer searching upward from rr_ptr, mod 4.
  - On grant, rr_ptr ← grant+1 (3 wraps to 0). rr_ptr does not change when nothing is granted.
- **Error counter.** corr_cnt increments at each load with s≠0 and saturates at 255. Only reset clears it.
- **Simultaneous events.** A buffer granted in cycle N shows in_ready=1 from N+1. A new input is never accepted into a buffer in its grant cycle.

## Timing
- **Reset values.** in_ready=4'b1111, out_valid=0, out_data=0, out_err=0, out_err_pos=0, corr_cnt=0, rr_ptr=0, all buffers empty, FSM=EMPTY.
- **Mid-operation reset.** Reset asserted during operation discards all buffered and output words immediately, without waiting for a clock.
- **Latency.** Word accepted at edge N, output free: out_valid=1 after edge N+1, so 2 cycles input-to-output.
- **Throughput.** Aggregate 1 word/cycle with continuous out_ready. Per port, 1 word every 2 cycles.
- **Outputs.** All outputs are registered; there is no combinational path from in_valid or out_ready to any output.

## Structure
- Package hamm_pkg holds:
  - NPORTS=4, CW_W=7, DATA_W=4, PORT_W=2, OUT_W=6;
  - the position-index constants;
  - a typedef for the codeword;
  - a struct {data, err, err_pos} for decode results.
- Sub-module hamm_syndrome_decode is purely combinational: codeword in, corrected nibble, err and pos out. It is instantiated once, on the granted buffer's output mux.
- Top-level contents: buffers, arbiter, output FSM, counter.

## Test plan
- **Clean word.** Reset; port 1 sends 7'b1010101 → after 2 cycles out_data=6'b01_1011, out_err=0, out_err_pos=0, corr_cnt=0.
- **Single-bit error.** Port 2 sends 7'b1010001 (position 3 flipped) → out_data=6'b10_1011, out_err=1, out_err_pos=3, corr_cnt=1. Sweep all 7 positions and all 16 nibbles.
- **Round-robin.** All four ports valid in the same cycle with distinct nibbles, out_ready=1 → outputs on 4 consecutive cycles in src order 0,1,2,3. Repeat with rr_ptr=2: order 2,3,0,1.
- **Backpressure.** out_ready=0 for 5 cycles with all ports loaded → out_data stable, in_ready=4'b0000 once all buffers are full, and no word lost or duplicated after release.
- **Counter saturation.** 300 corrupted words → corr_cnt stops at 255.
- **Async reset.** Assert rst_n=0 mid-burst between clock edges → out_valid=0 and in_ready=4'b1111 immediately. The first post-reset grant is port 0.
